// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: 2-flop sync, tick-sampled debounce,
// registered press/release strobes and a one-shot long-press strobe per channel.
module btn_debounce_multi #(
   parameter int N_CH       = 4,
   parameter int TICK_DIV   = 100000,
   parameter int STABLE_CNT = 8,
   parameter int LONG_CNT   = 1000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_press,
   output logic [N_CH-1:0] btn_release,
   output logic [N_CH-1:0] btn_long,
   output logic            tick
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int DW = $clog2(STABLE_CNT + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DCNT_LAST = DW'(STABLE_CNT - 1);

   logic [TW-1:0]   r_tcnt;
   logic            w_tick;
   logic [N_CH-1:0] r_sync1;
   logic [N_CH-1:0] r_sync2;
   logic [DW-1:0]   r_dcnt [N_CH];
   logic [N_CH-1:0] r_level;
   logic [N_CH-1:0] r_press;
   logic [N_CH-1:0] r_release;
   logic [N_CH-1:0] w_flip;

   // Shared sample tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt <= '0;
      end else if (w_tick) begin
         r_tcnt <= '0;
      end else begin
         r_tcnt <= r_tcnt + TW'(1);
      end
   end

   assign w_tick = (r_tcnt == TICK_LAST);
   assign tick   = w_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   // A channel flips on the tick that completes STABLE_CNT disagreeing samples
   always_comb begin
      w_flip = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_flip[i] = w_tick && (r_sync2[i] != r_level[i]) && (r_dcnt[i] == DCNT_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            r_dcnt[i] <= '0;
         end
      end else if (w_tick) begin
         for (int i = 0; i < N_CH; i++) begin
            if ((r_sync2[i] == r_level[i]) || w_flip[i]) begin
               r_dcnt[i] <= '0;
            end else begin
               r_dcnt[i] <= r_dcnt[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level   <= '0;
         r_press   <= '0;
         r_release <= '0;
      end else begin
         r_level   <= r_level ^ w_flip;
         r_press   <= w_flip & ~r_level;
         r_release <= w_flip & r_level;
      end
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;

   generate
      if (LONG_CNT > 0) begin : g_long
         localparam int HW = $clog2(LONG_CNT + 1);
         localparam logic [HW-1:0] HCNT_MAX = HW'(LONG_CNT);
         localparam logic [HW-1:0] HCNT_PRE = HW'(LONG_CNT - 1);

         logic [HW-1:0]   r_hcnt [N_CH];
         logic [N_CH-1:0] r_long;

         // Hold counter saturates so the strobe fires only once per hold
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_long <= '0;
               for (int i = 0; i < N_CH; i++) begin
                  r_hcnt[i] <= '0;
               end
            end else begin
               for (int i = 0; i < N_CH; i++) begin
                  r_long[i] <= 1'b0;
                  if (w_flip[i] && r_level[i]) begin
                     r_hcnt[i] <= '0;
                  end else if (w_tick && r_level[i] && (r_hcnt[i] != HCNT_MAX)) begin
                     r_hcnt[i] <= r_hcnt[i] + HW'(1);
                     r_long[i] <= (r_hcnt[i] == HCNT_PRE);
                  end
               end
            end
         end

         assign btn_long = r_long;
      end else begin : g_no_long
         assign btn_long = '0;
      end
   endgenerate

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button conditioner, successor to the single-channel 8-sample debouncer. Each channel is synchronised, debounced against a programmable stable-sample count on a shared internal sample tick, and produces a clean level, one-cycle press/release strobes and a one-shot long-press strobe. It sits between the board button/switch pins and all control logic, and replaces the external clock-divider tap with an internal tick generator.

## Interface
- N_CH, 4: number of independent channels.
- TICK_DIV, 100000: clk cycles per sample tick; 100000 gives 1 ms at 100 MHz. Must be ≥ 2.
- STABLE_CNT, 8: consecutive ticks on which the sample must differ from `btn_level` before the level flips. Must be ≥ 1.
- LONG_CNT, 1000: ticks `btn_level` must stay 1 before `btn_long` fires. 0 disables long-press.

- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_in  in  N_CH  raw asynchronous button levels; 1 = pressed.
- btn_level  out  N_CH  debounced level.
- btn_press  out  N_CH  one-cycle strobe on a debounced 0→1 transition.
- btn_release  out  N_CH  one-cycle strobe on a debounced 1→0 transition.
- btn_long  out  N_CH  one-cycle strobe when the hold reaches LONG_CNT ticks.
- tick  out  1  one-cycle sample strobe, exported for other slow logic.

## Operation
- **Reset (rst_n = 0):** all outputs, synchronisers, the tick counter and the per-channel counters go to 0 immediately. This applies mid-debounce or mid-hold. No strobes fire on reset release.
- **Synchroniser:** each `btn_in` bit passes through a 2-flop synchroniser. Call the output `s[i]`.
- **Tick generator:**
  - Counter width is clog2(TICK_DIV).
  - It counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` = 1 in the cycle the counter equals TICK_DIV-1, so there is one tick per TICK_DIV cycles.
  - The first tick after reset is in cycle TICK_DIV-1.
- **Debounce, per channel:** the counter `dcnt` has width clog2(STABLE_CNT+1). On a tick cycle:
  - If `s[i]` == `btn_level[i]`: `dcnt` ← 0.
  - Otherwise, if `dcnt` == STABLE_CNT-1: `btn_level[i]` toggles and `dcnt` ← 0.
  - Otherwise: `dcnt` ← `dcnt` + 1.
  - On non-tick cycles `dcnt` holds.
  - Any single agreeing sample restarts the count.
- **Edge strobes:**
  - `btn_press[i]` / `btn_release[i]` are registered. Each is 1 for exactly the one cycle in which the new `btn_level[i]` is first visible.
  - Press and release never coincide on one channel.
  - Channels are fully independent, and simultaneous events on several channels all strobe in the same cycle.
- **Long press, per channel** (`hcnt`, width clog2(LONG_CNT+1)):
  - While `btn_level[i]` = 1, each tick increments `hcnt`, saturating at LONG_CNT.
  - `btn_long[i]` pulses one cycle on the tick that moves `hcnt` to LONG_CNT. It fires once per hold.
  - `hcnt` ← 0 in the cycle `btn_level[i]` falls.
  - With LONG_CNT = 0, `btn_long` is tied 0 and `hcnt` is removed.

## Timing
- **Latency:** a clean input step to `btn_level` takes 2 synchroniser cycles, plus the wait to the first tick, plus (STABLE_CNT-1)·TICK_DIV, plus 1 register cycle.
  - Minimum: 3 + (STABLE_CNT-1)·TICK_DIV cycles.
  - Maximum: 2 + STABLE_CNT·TICK_DIV cycles.
- **Strobe alignment:** press/release strobes coincide with the `btn_level` change. `btn_long` is asserted the cycle after a tick, aligned with the `hcnt` update.
- **Long-press timing:** the first hold tick is the first tick after `btn_level` rises. `btn_long` fires LONG_CNT ticks after that rise.
- **Glitch rejection:** glitches shorter than 2 cycles may be missed entirely. Any glitch that is never sampled by a tick has no effect.

## Test plan
All scenarios use N_CH = 2, TICK_DIV = 4, STABLE_CNT = 3, LONG_CNT = 5.

1. **Reset:** hold rst_n = 0 with btn_in = 2'b11, then release → all outputs 0 in and after reset. `tick` first high in cycle 3 after release.
2. **Clean press:** btn_in[0] 0→1 held → `btn_level[0]` rises after exactly 3 agreeing ticks, within 11..14 cycles of the step. `btn_press[0]` is high for 1 cycle, aligned with the rise; channel 1 stays unchanged.
3. **Bounce:** btn_in[0] high for 2 ticks, low across 1 tick, then high → `dcnt` restarts. The level rises only after 3 further consecutive high ticks; no strobe fires before that.
4. **Long press and release:** hold channel 0 → `btn_long[0]` pulses once, 5 ticks after the level rises, and never again while held. Release → `btn_release[0]` pulses 1 cycle. A re-press re-arms `btn_long`.
5. **Simultaneous events:** both channels press in the same cycle → `btn_press` = 2'b11 for 1 cycle. Channel 0 release with a channel 1 hold → only `btn_release[0]` fires.
6. **Mid-operation reset:** assert rst_n = 0 while mid-hold with `hcnt` = 3 → outputs clear asynchronously. After release with the input still high, a full 3-tick debounce occurs before `btn_press` fires again.
